// File: rtl/mrd_frame_loader_pkg.sv
// Shared constants and state encoding for the MRD frame loader.
// Defaults describe a 16-column, 256-row channel frame delivered 16 elements per beat.
package mrd_frame_loader_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ROWS  = 256;
  localparam int DEF_COLS  = 16;
  localparam int DEF_LANES = 16;

  // Beats per frame: COLS columns of H plus the y vector, LANES elements each.
  function automatic int beats_of(int rows, int cols, int lanes);
    return (cols + 1) * rows / lanes;
  endfunction

  localparam int DEF_BEATS = beats_of(DEF_ROWS, DEF_COLS, DEF_LANES);
  localparam int DEF_CNT_W = $clog2(DEF_BEATS);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage

// File: rtl/mrd_frame_loader_if.sv
// Beat-stream handshake into the frame loader: payload, valid, last and ready.
interface mrd_frame_loader_if
  import mrd_frame_loader_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int WIDTH = DEF_WIDTH
);

  logic [LANES*WIDTH-1:0] in_data;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ready;

  modport master (output in_data, in_valid, in_last, input in_ready);
  modport slave  (input in_data, in_valid, in_last, output in_ready);

endinterface

// File: rtl/mrd_frame_shadow.sv
// Shadow frame store: one row per beat, written by beat index, read out as one flat bus.
module mrd_frame_shadow
  import mrd_frame_loader_pkg::*;
#(
  parameter int BEATS = DEF_BEATS,
  parameter int BW    = DEF_LANES * DEF_WIDTH,
  parameter int AW    = $clog2(BEATS)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [BW-1:0]       wdata,
  output logic [BEATS*BW-1:0] rd_flat
);

  logic [BW-1:0] mem [BEATS];

  // NOTE: storage has no reset; every row is rewritten by a full frame before it is committed.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_comb begin
    for (int b = 0; b < BEATS; b++) rd_flat[b*BW +: BW] = mem[b];
  end

endmodule

// File: rtl/mrd_frame_loader.sv
// Assembles a beat stream into the flat H/y buses, double-buffered so the committed
// frame stays stable while the next one loads.
module mrd_frame_loader
  import mrd_frame_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int LANES = DEF_LANES
) (
  input  logic                       clk,
  input  logic                       rst,
  mrd_frame_loader_if.slave          beat,
  output logic [COLS*ROWS*WIDTH-1:0] h_cols,
  output logic [ROWS*WIDTH-1:0]      y_vec,
  output logic                       frame_valid,
  input  logic                       frame_ack,
  output logic                       frame_start,
  output logic                       frame_err
);

  localparam int BEATS = beats_of(ROWS, COLS, LANES);
  localparam int CNT_W = $clog2(BEATS);
  localparam int BW    = LANES * WIDTH;
  localparam int HW    = COLS * ROWS * WIDTH;
  localparam int YW    = ROWS * WIDTH;

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   beat_cnt;
  logic [BEATS*BW-1:0] shadow_flat;
  logic               accept, last_slot, good_end, bad_end, commit;

  // NOTE: combinational blocks use blocking '=' so each value settles within the same evaluation.
  always_comb begin
    accept    = beat.in_valid && beat.in_ready;
    last_slot = (beat_cnt == CNT_W'(BEATS - 1));
    good_end  = accept && beat.in_last && last_slot;
    bad_end   = accept && (beat.in_last != last_slot);
    commit    = (state == FULL) && (!frame_valid || frame_ack);
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (good_end) state_nxt = FULL;
      FULL: if (commit)   state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    beat.in_ready = (state == LOAD) && !rst;
  end

  mrd_frame_shadow #(
    .BEATS (BEATS),
    .BW    (BW),
    .AW    (CNT_W)
  ) u_shadow (
    .clk     (clk),
    .we      (accept),
    .addr    (beat_cnt),
    .wdata   (beat.in_data),
    .rd_flat (shadow_flat)
  );

  // A framing error or a good end both restart the counter for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt    <= '0;
      frame_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_err   <= 1'b0;
      h_cols      <= '0;
      y_vec       <= '0;
    end else begin
      frame_start <= commit;
      frame_err   <= bad_end;
      if (accept) beat_cnt <= (beat.in_last || last_slot) ? '0 : beat_cnt + 1'b1;
      if (commit) begin
        frame_valid <= 1'b1;
        h_cols      <= shadow_flat[HW-1:0];
        y_vec       <= shadow_flat[HW +: YW];
      end else if (frame_ack) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mrd_frame_loader.sv
// Self-checking bench for mrd_frame_loader: frame-level reference model plus directed cases.
module tb_mrd_frame_loader;
  import mrd_frame_loader_pkg::*;

  localparam int W     = DEF_WIDTH;
  localparam int ROWS  = DEF_ROWS;
  localparam int COLS  = DEF_COLS;
  localparam int LANES = DEF_LANES;
  localparam int BEATS = DEF_BEATS;
  localparam int BW    = LANES * W;
  localparam int HW    = COLS * ROWS * W;
  localparam int YW    = ROWS * W;
  localparam int NELEM = BEATS * LANES;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_ack = 1'b0;
  logic [HW-1:0] h_cols;
  logic [YW-1:0] y_vec;
  logic          frame_valid, frame_start, frame_err;

  mrd_frame_loader_if bi ();

  mrd_frame_loader dut (
    .clk         (clk),
    .rst         (rst),
    .beat        (bi),
    .h_cols      (h_cols),
    .y_vec       (y_vec),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .frame_start (frame_start),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  int err_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bus(input string name, input logic [HW-1:0] ah, input logic [YW-1:0] ay,
                           input logic [HW-1:0] eh, input logic [YW-1:0] ey);
    total++;
    if (ah !== eh || ay !== ey) begin
      bad++;
      for (int e = 0; e < NELEM; e++) begin
        logic [W-1:0] a, x;
        if (e < COLS*ROWS) begin a = ah[e*W +: W]; x = eh[e*W +: W]; end
        else begin a = ay[(e-COLS*ROWS)*W +: W]; x = ey[(e-COLS*ROWS)*W +: W]; end
        if (a !== x) begin
          $display("FAIL %s: element %0d got 0x%0h expected 0x%0h at %0t", name, e, a, x, $time);
          break;
        end
      end
    end
  endtask

  // ---------------- reference model (frame/element level) ----------------
  logic [W-1:0]  m_cur  [NELEM];
  logic [W-1:0]  m_pend [NELEM];
  logic [HW-1:0] m_h, snap_h;
  logic [YW-1:0] m_y, snap_y;
  bit            m_full, m_valid, m_start, m_err, chk_en = 1'b0;
  bit            can_take, do_commit;
  int            m_pos;

  // Place each element per the column-major H / trailing y rule.
  task automatic publish();
    for (int e = 0; e < NELEM; e++) begin
      if (e < COLS*ROWS) m_h[(e / ROWS)*ROWS*W + (e % ROWS)*W +: W] = m_pend[e];
      else               m_y[(e - COLS*ROWS)*W +: W] = m_pend[e];
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_pos = 0; m_full = 0; m_valid = 0; m_start = 0; m_err = 0;
      m_h = '0; m_y = '0; chk_en = 1'b1;
    end else begin
      can_take  = !m_full;
      do_commit = m_full && (!m_valid || frame_ack);
      m_start   = do_commit;
      m_err     = 0;
      if (m_valid && frame_ack) m_valid = 0;
      if (do_commit) begin
        publish();
        m_valid = 1;
        m_full  = 0;
      end
      if (can_take && bi.in_valid) begin
        for (int i = 0; i < LANES; i++) m_cur[m_pos*LANES + i] = bi.in_data[i*W +: W];
        if (bi.in_last && m_pos == BEATS-1) begin
          m_pend = m_cur; m_full = 1; m_pos = 0;
        end else if (bi.in_last || m_pos == BEATS-1) begin
          m_err = 1; m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", bi.in_ready, !rst && !m_full);
      check("frame_valid", frame_valid, m_valid);
      check("frame_start", frame_start, m_start);
      check("frame_err", frame_err, m_err);
      check_bus("buses", h_cols, y_vec, m_h, m_y);
      if (frame_start === 1'b1) start_cnt++;
      if (frame_err === 1'b1) err_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic ack();
    frame_ack = 1'b1; tick(); frame_ack = 1'b0;
  endtask

  function automatic logic [BW-1:0] beat_data(input int seed, input int b);
    logic [BW-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*W +: W] = W'((b*LANES + i + seed) % 256);
    return d;
  endfunction

  task automatic send_beat(input logic [BW-1:0] d, input logic last, input bit bubbles);
    bit xfer = 1'b0;
    int guard = 0;
    if (bubbles) while ($urandom_range(1, 0) == 0) begin bi.in_valid = 1'b0; tick(); end
    bi.in_data = d; bi.in_last = last; bi.in_valid = 1'b1;
    while (!xfer && guard < 1000) begin
      @(negedge clk); xfer = (bi.in_ready === 1'b1);
      tick(); guard++;
    end
    bi.in_valid = 1'b0; bi.in_last = 1'b0;
    if (!xfer) begin
      total++; bad++;
      $display("FAIL beat_timeout: got no transfer expected transfer within 1000 cycles at %0t", $time);
    end
  endtask

  task automatic send_frame(input int seed, input int nbeats, input int last_at, input bit bubbles);
    for (int b = 0; b < nbeats; b++) send_beat(beat_data(seed, b), b == last_at, bubbles);
  endtask

  function automatic logic [W-1:0] h_el(input int c, input int r);
    return h_cols[c*ROWS*W + r*W +: W];
  endfunction

  function automatic logic [W-1:0] y_el(input int r);
    return y_vec[r*W +: W];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bi.in_data = '0; bi.in_valid = 1'b0; bi.in_last = 1'b0;
    rst = 1'b1;
    idle(3);
    check("rst_valid", frame_valid, 0);
    check("rst_ready", bi.in_ready, 0);
    check("rst_h_c0r0", h_el(0, 0), 8'h00);
    rst = 1'b0;
    tick();

    // 1: clean frame, pattern (b*16+i) mod 256
    send_frame(0, BEATS, BEATS-1, 0);
    idle(4);
    check("c1_valid", frame_valid, 1);
    check("c1_h_c0r0", h_el(0, 0), 8'h00);
    check("c1_h_c0r1", h_el(0, 1), 8'h01);
    check("c1_h_c1r0", h_el(1, 0), 8'h00);
    check("c1_h_c15r255", h_el(15, 255), 8'hFF);
    check("c1_y0", y_el(0), 8'h00);
    check("c1_y15", y_el(15), 8'h0F);
    check("c1_start_pulses", start_cnt, 1);
    check("c1_err_pulses", err_cnt, 0);
    snap_h = m_h; snap_y = m_y;
    ack();
    idle(2);
    check("c1_acked", frame_valid, 0);

    // 2: early last on beat 100, then a clean frame
    send_frame(8'h10, 101, 100, 0);
    idle(3);
    check("c2_err_pulses", err_cnt, 1);
    check("c2_no_commit", start_cnt, 1);
    check("c2_valid", frame_valid, 0);
    send_frame(8'h10, BEATS, BEATS-1, 0);
    idle(4);
    check("c2_start_pulses", start_cnt, 2);
    check("c2_h_c0r0", h_el(0, 0), 8'h10);
    check("c2_y0", y_el(0), 8'h10);
    ack();
    idle(2);

    // 3: missing last on beat 271, counter restarts for the next frame
    send_frame(8'h20, BEATS, -1, 0);
    idle(3);
    check("c3_err_pulses", err_cnt, 2);
    check("c3_valid", frame_valid, 0);
    send_frame(8'h21, BEATS, BEATS-1, 0);
    idle(4);
    check("c3_start_pulses", start_cnt, 3);
    check("c3_h_c0r0", h_el(0, 0), 8'h21);
    check("c3_h_c15r255", h_el(15, 255), 8'h20);
    ack();
    idle(2);

    // 4: back-to-back frames without ack; B waits in FULL
    send_frame(8'h30, BEATS, BEATS-1, 0);
    send_frame(8'h55, BEATS, BEATS-1, 0);
    idle(5);
    check("c4_ready_blocked", bi.in_ready, 0);
    check("c4_valid", frame_valid, 1);
    check("c4_keeps_a", h_el(0, 0), 8'h30);
    check("c4_start_pulses", start_cnt, 4);
    ack();
    check("c4_valid_after_ack", frame_valid, 1);
    check("c4_h_c0r0_b", h_el(0, 0), 8'h55);
    check("c4_y15_b", y_el(15), 8'h64);
    idle(2);
    check("c4_start_pulses_b", start_cnt, 5);
    check("c4_ready_again", bi.in_ready, 1);
    ack();
    idle(2);

    // 5: 50% valid bubbles give the same committed frame as case 1
    send_frame(0, BEATS, BEATS-1, 1);
    idle(4);
    check("c5_start_pulses", start_cnt, 6);
    check_bus("c5_same_as_c1", h_cols, y_vec, snap_h, snap_y);

    // 6: reset mid-frame at beat 150
    send_frame(8'h77, 150, -1, 0);
    rst = 1'b1;
    tick();
    check("c6_rst_valid", frame_valid, 0);
    check("c6_rst_ready", bi.in_ready, 0);
    check("c6_rst_start", frame_start, 0);
    check_bus("c6_rst_buses", h_cols, y_vec, '0, '0);
    tick();
    rst = 1'b0;
    tick();
    send_frame(8'h99, BEATS, BEATS-1, 0);
    idle(4);
    check("c6_valid", frame_valid, 1);
    check("c6_h_c0r0", h_el(0, 0), 8'h99);
    check("c6_y0", y_el(0), 8'h99);
    check("c6_start_pulses", start_cnt, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
